// File: rtl/atomrvcore_dccm_lsu.sv
// Data closely-coupled memory with load/store unit for the atomRVCORE memory stage.
// Byte/half/word stores with lane enables, extending loads, split or flagged misaligned accesses.
module atomrvcore_dccm_lsu #(
    parameter int DATAWIDTH        = 32,
    parameter int ADDRESS_BUS      = 10,
    parameter int REG_ADRESS_WIDTH = 5,
    parameter bit MISALIGN_SPLIT   = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [DATAWIDTH-1:0]        address_i,
    input  logic                        DWR_EN_i,
    input  logic                        DR_EN_i,
    input  logic [2:0]                  funct3_i,
    input  logic [DATAWIDTH-1:0]        DT_i,
    input  logic [REG_ADRESS_WIDTH-1:0] RD_i,
    input  logic                        RWR_EN_i,
    input  logic [DATAWIDTH-1:0]        result_i,
    output logic                        stall_o,
    output logic                        misalign_o,
    output logic                        RWR_EN_o,
    output logic                        DR_EN_o,
    output logic [REG_ADRESS_WIDTH-1:0] RD_o,
    output logic [DATAWIDTH-1:0]        DT_o,
    output logic [DATAWIDTH-1:0]        WR_o
);

    localparam int DEPTH = 2 ** ADDRESS_BUS;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t                 state_q;
    logic [DATAWIDTH-1:0]   stage_q;
    logic [DATAWIDTH-1:0]   mem [DEPTH];

    logic [1:0]             off;
    logic [ADDRESS_BUS-1:0] idx_lo;
    logic [ADDRESS_BUS-1:0] idx_hi;
    logic [3:0]             size_mask;
    logic [7:0]             lane_mask8;
    logic [63:0]            st_data64;
    logic [DATAWIDTH-1:0]   lo_word;
    logic [DATAWIDTH-1:0]   ld_raw;
    logic                   access;
    logic                   crossing;
    logic                   split_first;
    logic                   suppress;
    logic                   load_ok;
    logic [3:0]             we_lo;
    logic [3:0]             we_hi;
    logic                   unused_addr;

    function automatic logic [DATAWIDTH-1:0] extend_load(input logic [DATAWIDTH-1:0] raw,
                                                         input logic [2:0] f3);
        logic [DATAWIDTH-1:0] res;
        case (f3[1:0])
            2'b00:   res = f3[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = f3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign off         = address_i[1:0];
    assign idx_lo      = address_i[ADDRESS_BUS+1:2];
    assign idx_hi      = idx_lo + ADDRESS_BUS'(1);
    assign unused_addr = ^address_i[DATAWIDTH-1:ADDRESS_BUS+2];

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Lanes [3:0] address word N, lanes [7:4] spill into word N+1.
    assign lane_mask8  = {4'b0, size_mask} << off;
    assign st_data64   = {32'b0, DT_i} << {off, 3'b000};
    assign crossing    = |lane_mask8[7:4];
    assign access      = DWR_EN_i | DR_EN_i;
    assign split_first = MISALIGN_SPLIT && (state_q == IDLE) && access && crossing;
    assign suppress    = !MISALIGN_SPLIT && access && crossing;
    assign stall_o     = split_first;
    assign load_ok     = DR_EN_i && !DWR_EN_i && !suppress;

    assign lo_word = (state_q == SECOND) ? stage_q : mem[idx_lo];
    assign ld_raw  = 32'({mem[idx_hi], lo_word} >> {off, 3'b000});

    always_comb begin
        we_lo = 4'b0;
        we_hi = 4'b0;
        // Reset gates writes so a second split part in flight is dropped.
        if (rst_ni && DWR_EN_i && !suppress) begin
            if (state_q == SECOND) we_hi = lane_mask8[7:4];
            else                   we_lo = lane_mask8[3:0];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_lo[b]) mem[idx_lo][8*b +: 8] <= st_data64[8*b +: 8];
            if (we_hi[b]) mem[idx_hi][8*b +: 8] <= st_data64[32+8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            misalign_o <= 1'b0;
            RWR_EN_o   <= 1'b0;
            DR_EN_o    <= 1'b0;
            RD_o       <= '0;
            DT_o       <= '0;
            WR_o       <= '0;
        end else begin
            RD_o       <= RD_i;
            WR_o       <= result_i;
            misalign_o <= suppress;
            case (state_q)
                IDLE: begin
                    if (split_first) begin
                        state_q  <= SECOND;
                        stage_q  <= mem[idx_lo];
                        RWR_EN_o <= 1'b0;
                        DR_EN_o  <= 1'b0;
                    end else begin
                        RWR_EN_o <= RWR_EN_i && !suppress;
                        DR_EN_o  <= load_ok;
                        if (load_ok) DT_o <= extend_load(ld_raw, funct3_i);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    RWR_EN_o <= RWR_EN_i;
                    DR_EN_o  <= load_ok;
                    if (load_ok) DT_o <= extend_load(ld_raw, funct3_i);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atomrvcore_dccm_lsu.sv
// Bench for atomrvcore_dccm_lsu: directed vector table, reset/split corners, random ops
// against a byte-addressed memory model, plus a flag-mode instance.
module tb_atomrvcore_dccm_lsu;

    localparam int AB     = 10;
    localparam int NBYTES = 4 * (2 ** AB);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, dwr, drd, rwr;
    logic [31:0] addr, dt, res;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        stall, mis, rwr_o, dr_o;
    logic [4:0]  rd_o;
    logic [31:0] dt_o, wr_o;

    logic        rst_nn, dwr_n, drd_n, rwr_n;
    logic [31:0] addr_n, dt_n, res_n;
    logic [2:0]  f3_n;
    logic [4:0]  rd_n;
    logic        stall_n, mis_n, rwr_on, dr_on;
    logic [4:0]  rd_on;
    logic [31:0] dt_on, wr_on;

    atomrvcore_dccm_lsu #(.DATAWIDTH(32), .ADDRESS_BUS(AB), .REG_ADRESS_WIDTH(5), .MISALIGN_SPLIT(1'b1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .address_i(addr), .DWR_EN_i(dwr), .DR_EN_i(drd),
        .funct3_i(f3), .DT_i(dt), .RD_i(rd), .RWR_EN_i(rwr), .result_i(res),
        .stall_o(stall), .misalign_o(mis), .RWR_EN_o(rwr_o), .DR_EN_o(dr_o),
        .RD_o(rd_o), .DT_o(dt_o), .WR_o(wr_o));

    atomrvcore_dccm_lsu #(.DATAWIDTH(32), .ADDRESS_BUS(AB), .REG_ADRESS_WIDTH(5), .MISALIGN_SPLIT(1'b0)) u_flag (
        .clk_i(clk), .rst_ni(rst_nn), .address_i(addr_n), .DWR_EN_i(dwr_n), .DR_EN_i(drd_n),
        .funct3_i(f3_n), .DT_i(dt_n), .RD_i(rd_n), .RWR_EN_i(rwr_n), .result_i(res_n),
        .stall_o(stall_n), .misalign_o(mis_n), .RWR_EN_o(rwr_on), .DR_EN_o(dr_on),
        .RD_o(rd_on), .DT_o(dt_on), .WR_o(wr_on));

    logic [7:0]  mdl [NBYTES];
    logic [31:0] last_dt;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] d;
        logic [31:0] exp;
        logic        stl;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] raw = '0;
        int n = nbytes(f);
        int base = int'(a[AB+1:0]);
        for (int i = 0; i < n; i++) raw[8*i +: 8] = mdl[(base + i) % NBYTES];
        if (!f[2] && n < 4 && raw[8*n-1]) raw = raw | ~((32'h1 << (8*n)) - 32'h1);
        return raw;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        int n = nbytes(f);
        int base = int'(a[AB+1:0]);
        for (int i = 0; i < n; i++) mdl[(base + i) % NBYTES] = d[8*i +: 8];
    endtask

    task automatic op(input logic st, input logic ld, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] d, input logic [4:0] r, input logic we,
                      input logic [31:0] rv, input logic [31:0] exp_dt, input logic exp_stall);
        dwr = st; drd = ld; addr = a; f3 = f; dt = d; rd = r; rwr = we; res = rv;
        #1;
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        if (exp_stall) begin
            @(posedge clk); #1;
            chk("bubble_rwr_en", {31'b0, rwr_o}, 32'd0);
            chk("bubble_dr_en", {31'b0, dr_o}, 32'd0);
            chk("stall_second", {31'b0, stall}, 32'd0);
        end
        @(posedge clk); #1;
        chk("rwr_en", {31'b0, rwr_o}, {31'b0, we});
        chk("rd", {27'b0, rd_o}, {27'b0, r});
        chk("wr", wr_o, rv);
        chk("dr_en", {31'b0, dr_o}, {31'b0, ld && !st});
        chk("misalign", {31'b0, mis}, 32'd0);
        if (ld && !st) last_dt = exp_dt;
        chk("dt", dt_o, last_dt);
        if (st) model_store(a, f, d);
    endtask

    task automatic ns_cycle(input logic st, input logic ld, input logic [31:0] a, input logic [2:0] f,
                            input logic [31:0] d, input logic [4:0] r, input logic we, input logic [31:0] rv);
        dwr_n = st; drd_n = ld; addr_n = a; f3_n = f; dt_n = d; rd_n = r; rwr_n = we; res_n = rv;
        #1;
        chk("flag_stall", {31'b0, stall_n}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; dwr = 0; drd = 0; rwr = 0; addr = 0; dt = 0; res = 0; f3 = 0; rd = 0;
        rst_nn = 0; dwr_n = 0; drd_n = 0; rwr_n = 0; addr_n = 0; dt_n = 0; res_n = 0; f3_n = 0; rd_n = 0;
        last_dt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rwr_en", {31'b0, rwr_o}, 32'd0);
        chk("reset_dr_en", {31'b0, dr_o}, 32'd0);
        chk("reset_rd", {27'b0, rd_o}, 32'd0);
        chk("reset_dt", dt_o, 32'd0);
        chk("reset_wr", wr_o, 32'd0);
        chk("reset_misalign", {31'b0, mis}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        rst_n = 1; rst_nn = 1;

        for (int w = 0; w < NBYTES / 4; w++) op(1, 0, 32'(4*w), 3'b010, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

        tbl.push_back('{1'b1, 1'b0, 32'h040, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h040, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h041, 3'b000, 32'h7F,       32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h041, 3'b000, 32'h0,        32'h0000007F, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h041, 3'b000, 32'h80,       32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h041, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h041, 3'b100, 32'h0,        32'h00000080, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h040, 3'b010, 32'h0,        32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h043, 3'b001, 32'hA5C3,     32'h0,        1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h040, 3'b010, 32'h0,        32'hC3AD80EF, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h044, 3'b010, 32'h0,        32'h000000A5, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h043, 3'b001, 32'h0,        32'hFFFFA5C3, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'hFFE, 3'b010, 32'h11223344, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'hFFC, 3'b010, 32'h0,        32'h33440000, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h000, 3'b010, 32'h0,        32'h00001122, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'hFFE, 3'b010, 32'h0,        32'h11223344, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h042, 3'b101, 32'h0,        32'h0000C3AD, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h042, 3'b001, 32'h0,        32'hFFFFC3AD, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h080, 3'b010, 32'h12345678, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h080, 3'b011, 32'h0,        32'h12345678, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h080, 3'b010, 32'h0,        32'h0,        1'b0});
        for (int i = 0; i < tbl.size(); i++)
            op(tbl[i].st, tbl[i].ld, tbl[i].a, tbl[i].f, tbl[i].d, 5'(i + 1), i[0],
               32'(i) * 32'h01010101, tbl[i].exp, tbl[i].stl);

        // Reset lands in the second half of a split store.
        op(1, 0, 32'h100, 3'b010, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        op(1, 0, 32'h104, 3'b010, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);
        dwr = 1; drd = 0; addr = 32'h101; f3 = 3'b010; dt = 32'hAABBCCDD; rd = 5'd5; rwr = 1; res = 32'h1;
        #1;
        chk("rst2_stall_first", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("rst2_stall_second", {31'b0, stall}, 32'd0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; dwr = 0; rwr = 0; addr = 0; rd = 0; res = 0;
        #1;
        chk("rst2_rwr_en", {31'b0, rwr_o}, 32'd0);
        chk("rst2_dr_en", {31'b0, dr_o}, 32'd0);
        chk("rst2_rd", {27'b0, rd_o}, 32'd0);
        chk("rst2_dt", dt_o, 32'd0);
        chk("rst2_wr", wr_o, 32'd0);
        chk("rst2_stall", {31'b0, stall}, 32'd0);
        last_dt = 0;
        mdl[32'h101] = 8'hDD; mdl[32'h102] = 8'hCC; mdl[32'h103] = 8'hBB;
        op(0, 1, 32'h100, 3'b010, 32'h0, 5'd1, 1'b1, 32'h2, 32'hBBCCDD00, 1'b0);
        op(0, 1, 32'h104, 3'b010, 32'h0, 5'd2, 1'b1, 32'h3, 32'h00000000, 1'b0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            logic [2:0]  f;
            int          kind;
            logic        st, ld;
            kind = $urandom_range(0, 3);
            st = (kind == 0) || (kind == 2);
            ld = (kind == 1) || (kind == 2);
            a = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(4080, 4095));
            a = a | (32'($urandom_range(0, 7)) << 12);
            f = 3'($urandom_range(0, 7));
            op(st, ld, a, f, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
               model_load(a, f), (st || ld) && (int'(a[1:0]) + nbytes(f) > 4));
        end

        ns_cycle(1, 0, 32'h040, 3'b010, 32'h55667788, 5'd1, 1'b1, 32'h100);
        chk("flag_store_misalign", {31'b0, mis_n}, 32'd0);
        chk("flag_store_rwr_en", {31'b0, rwr_on}, 32'd1);
        ns_cycle(1, 0, 32'h044, 3'b010, 32'h99AABBCC, 5'd2, 1'b0, 32'h101);
        ns_cycle(0, 1, 32'h042, 3'b010, 32'h0, 5'd9, 1'b1, 32'hBEEF);
        chk("flag_lw_misalign", {31'b0, mis_n}, 32'd1);
        chk("flag_lw_dr_en", {31'b0, dr_on}, 32'd0);
        chk("flag_lw_rwr_en", {31'b0, rwr_on}, 32'd0);
        chk("flag_lw_rd", {27'b0, rd_on}, 32'd9);
        chk("flag_lw_wr", wr_on, 32'hBEEF);
        ns_cycle(0, 0, 32'h0, 3'b010, 32'h0, 5'd3, 1'b1, 32'h5);
        chk("flag_idle_misalign", {31'b0, mis_n}, 32'd0);
        chk("flag_idle_rwr_en", {31'b0, rwr_on}, 32'd1);
        ns_cycle(1, 0, 32'h042, 3'b010, 32'h01020304, 5'd4, 1'b1, 32'h6);
        chk("flag_sw_misalign", {31'b0, mis_n}, 32'd1);
        ns_cycle(0, 1, 32'h040, 3'b010, 32'h0, 5'd5, 1'b1, 32'h7);
        chk("flag_word0_dr_en", {31'b0, dr_on}, 32'd1);
        chk("flag_word0", dt_on, 32'h55667788);
        ns_cycle(0, 1, 32'h044, 3'b010, 32'h0, 5'd6, 1'b1, 32'h8);
        chk("flag_word1", dt_on, 32'h99AABBCC);
        ns_cycle(0, 1, 32'h041, 3'b001, 32'h0, 5'd7, 1'b1, 32'h9);
        chk("flag_lh_inword", dt_on, 32'h00006677);
        chk("flag_lh_inword_misalign", {31'b0, mis_n}, 32'd0);
        ns_cycle(0, 1, 32'h043, 3'b001, 32'h0, 5'd8, 1'b1, 32'hA);
        chk("flag_lh_cross_misalign", {31'b0, mis_n}, 32'd1);
        chk("flag_lh_cross_dr_en", {31'b0, dr_on}, 32'd0);
        chk("flag_lh_cross_dt_hold", dt_on, 32'h00006677);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/atomrvcore_dccm_lsu.md
Name: atomrvcore_dccm_lsu

Overview:
Parametrised data closely-coupled memory with load/store unit for the atomRVCORE memory stage. Adds byte/halfword/word stores with byte-lane enables, sign/zero-extending loads, and misaligned-access handling, either split into two word accesses or flagged. Writeback sideband (RWR_EN/RD/result) is registered one stage alongside load data and held during split stalls.

Parameters:
DATAWIDTH, 32, datapath width; only 32 supported.
ADDRESS_BUS, 10, log2 of memory depth in 32-bit words (2**ADDRESS_BUS entries).
REG_ADRESS_WIDTH, 5, destination register index width.
MISALIGN_SPLIT, 1, 1 = word-crossing accesses split into two cycles; 0 = suppressed and flagged.

Ports:
clk_i  in  1  clock; all state on rising edge.
rst_ni  in  1  synchronous, active-low reset.
address_i  in  DATAWIDTH  byte address; word index = address_i[ADDRESS_BUS+1:2], upper bits ignored.
DWR_EN_i  in  1  store request.
DR_EN_i  in  1  load request.
funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
DT_i  in  DATAWIDTH  store data, LSB-justified.
RD_i  in  REG_ADRESS_WIDTH  destination register.
RWR_EN_i  in  1  register write enable.
result_i  in  DATAWIDTH  ALU result.
stall_o  out  1  combinational; upstream holds all inputs while 1.
misalign_o  out  1  registered; misaligned access suppressed (MISALIGN_SPLIT=0 only).
RWR_EN_o  out  1  registered RWR_EN_i.
DR_EN_o  out  1  registered; load data valid on DT_o.
RD_o  out  REG_ADRESS_WIDTH  registered RD_i.
DT_o  out  DATAWIDTH  extended load data.
WR_o  out  DATAWIDTH  registered result_i.

Behaviour:
- Reset (rst_ni=0 at edge): all outputs 0, FSM to IDLE, staging regs 0. Memory array not reset.
- Size from funct3_i[1:0] (00 byte, 01 half, 10 word). Extension from funct3_i[2] (0 sign, 1 zero). funct3_i 011/110/111 treated as word.
- Store: write only the addressed byte lanes. Data is shifted to lane address_i[1:0]. Other lanes unchanged.
- Load: read the word, shift right by 8*address_i[1:0], then extend. Latency 1: DT_o and DR_EN_o are valid the cycle after the request. DT_o holds its last value when no load completes.
- DWR_EN_i and DR_EN_i both 1: the store executes, the load is ignored, and DR_EN_o=0.
- Load in the cycle after a store to the same word returns the new data.
- Aligned, or misaligned but within one word (e.g. half at offset 1): single cycle, stall_o=0.
- Word-crossing access (half at offset 3; word at offset 1/2/3), MISALIGN_SPLIT=1:
  - IDLE: stall_o=1 combinationally. Access word N with lanes offset..3. Latch partial load bytes. Go to SECOND. The outputs clocked at this edge are a bubble (RWR_EN_o=0, DR_EN_o=0).
  - SECOND: stall_o=0. Access word N+1 with the remaining low lanes. Index wraps from 2**ADDRESS_BUS-1 to 0. Merge bytes, extend, register with sideband. Return to IDLE.
- Word-crossing access, MISALIGN_SPLIT=0: no memory write. Next cycle misalign_o=1, DR_EN_o=0, RWR_EN_o=0, RD_o/WR_o registered as normal. stall_o stays 0.
- Sideband without memory access: RWR_EN/RD/result pass through registered, latency 1, stall_o=0.
- Reset during SECOND: FSM to IDLE. The first-part store write is already committed; the second part is dropped.
- Inputs changing while stall_o=1 is illegal. The FSM uses the SECOND-cycle inputs, which must equal the IDLE-cycle inputs.

Test Plan:
- SW 0xDEADBEEF to 0x40, then LW 0x40 -> DT_o=0xDEADBEEF, DR_EN_o=1 one cycle later; RD_o and RWR_EN_o match, delayed 1.
- After that, SB 0x7F to 0x41, then LB 0x41 -> 0x0000007F; SB 0x80 to 0x41, then LB -> 0xFFFFFF80, LBU -> 0x00000080; LW 0x40 -> 0xDEAD80EF.
- SH 0xA5C3 to 0x43 (split) -> stall_o=1 for 1 cycle; bubble output; word 0x40 byte3=0xC3, word 0x44 byte0=0xA5. LH 0x43 -> 0xFFFFA5C3 after 2 cycles.
- SW 0x11223344 to the top-of-memory word with offset 2 -> low half in the last word lanes 2/3 (0x3344), high half in word 0 lanes 0/1 (0x1122). LW with the same address -> 0x11223344.
- MISALIGN_SPLIT=0: LW 0x42 -> misalign_o=1 for 1 cycle, DR_EN_o=0, RWR_EN_o=0, memory unchanged.
- Split store in progress, rst_ni=0 in SECOND -> all outputs 0, stall_o=0 next cycle, first word updated, second word unchanged.
